// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around the 16-bit ripple ALU.
// Registers a command, drives the ALU for one cycle, then holds the result for downstream.
module alu_issue_ctrl #(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct,
    input  logic [W-1:0]     in_src1,
    input  logic [W-1:0]     in_src2,
    output logic [W-1:0]     alu_src1,
    output logic [W-1:0]     alu_src2,
    output logic             alu_invert_a,
    output logic             alu_invert_b,
    output logic [1:0]       alu_operation,
    input  logic [W-1:0]     alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_illegal,
    output logic             sticky_ovf,
    input  logic             sticky_ovf_clr,
    output logic [CNT_W-1:0] issue_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_e;

    state_e state_q, state_d;
    logic   accept;
    logic   capture;

    logic       dec_inv_a;
    logic       dec_inv_b;
    logic [1:0] dec_op;
    logic       dec_arith;
    logic       dec_ill;

    logic [W-1:0]     src1_q, src2_q;
    logic             inv_a_q, inv_b_q;
    logic [1:0]       op_q;
    logic             arith_q, ill_q;
    logic [W-1:0]     res_q;
    logic             zero_q, ovf_q, ill_out_q;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; DONE hands in_ready over to out_ready
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? S_EXEC : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign accept  = in_valid & in_ready;
    assign capture = (state_q == S_EXEC);

    // Funct to ALU control decode; illegal funct drives a harmless AND
    always_comb begin
        dec_inv_a = 1'b0;
        dec_inv_b = 1'b0;
        dec_op    = 2'b00;
        dec_arith = 1'b0;
        dec_ill   = 1'b0;
        unique case (in_funct)
            3'b000: begin dec_op = 2'b10; dec_arith = 1'b1; end
            3'b001: begin dec_inv_b = 1'b1; dec_op = 2'b10; dec_arith = 1'b1; end
            3'b010: begin dec_op = 2'b00; end
            3'b011: begin dec_op = 2'b01; end
            3'b100: begin dec_inv_a = 1'b1; dec_inv_b = 1'b1; dec_op = 2'b00; end
            3'b101: begin dec_inv_a = 1'b1; dec_inv_b = 1'b1; dec_op = 2'b01; end
            3'b110: begin dec_inv_b = 1'b1; dec_op = 2'b11; end
            default: begin dec_ill = 1'b1; end
        endcase
    end

    // Command registers feeding the ALU; they hold until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src1_q  <= '0;
            src2_q  <= '0;
            inv_a_q <= 1'b0;
            inv_b_q <= 1'b0;
            op_q    <= 2'b00;
            arith_q <= 1'b0;
            ill_q   <= 1'b0;
        end else if (accept) begin
            src1_q  <= in_src1;
            src2_q  <= in_src2;
            inv_a_q <= dec_inv_a;
            inv_b_q <= dec_inv_b;
            op_q    <= dec_op;
            arith_q <= dec_arith;
            ill_q   <= dec_ill;
        end
    end

    // Result capture at the end of EXEC; overflow only means something for ADD/SUB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ill_out_q <= 1'b0;
        end else if (capture) begin
            res_q     <= ill_q ? '0 : alu_result;
            zero_q    <= ~ill_q & alu_zero;
            ovf_q     <= arith_q & alu_overflow;
            ill_out_q <= ill_q;
        end
    end

    // Sticky overflow: a same-cycle set beats the clear
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_ovf_clr) sticky_d = 1'b0;
        if (capture && arith_q && alu_overflow) sticky_d = 1'b1;
    end

    assign cnt_d = accept ? cnt_q + 1'b1 : cnt_q;

    // Sticky flag and free-running issue counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign alu_src1      = src1_q;
    assign alu_src2      = src2_q;
    assign alu_invert_a  = inv_a_q;
    assign alu_invert_b  = inv_b_q;
    assign alu_operation = op_q;
    assign out_result    = res_q;
    assign out_zero      = zero_q;
    assign out_overflow  = ovf_q;
    assign out_illegal   = ill_out_q;
    assign sticky_ovf    = sticky_q;
    assign issue_count   = cnt_q;

endmodule
